// File: rtl/inst_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue_pkg
// Shared types for the instruction fetch queue.
//   fq_state_e : fetch FSM state (RUN issues requests, DRAIN drops stale responses)
//   fq_entry_t : one queue entry, instruction address plus instruction word
// -----------------------------------------------------------------------------
package inst_fetch_queue_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fq_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fq_entry_t;

    localparam int ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous clear and an occupancy count. Read data is
// the head entry, valid whenever count != 0. Push and pop may occur in the same
// cycle, including when full; the caller guarantees no overflow/underflow.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           synchronous clear of pointers and count (overrides push/pop)
//   push, wdata   write an entry at the tail
//   pop           remove the head entry
//   rdata         head entry
//   count         number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Wrap explicitly so a non-power-of-two DEPTH still cycles modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        else                        return p + 1'b1;
    endfunction

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = ptr_inc(wptr_q);
            if (pop)  rptr_d = ptr_inc(rptr_q);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: the storage array has no reset; its contents are only observed
    // through count, so resetting it would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign count = cnt_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
// Decouples the PC stage from decode. Requests are issued to instruction memory
// only when a queue slot is reserved for every outstanding response, so the
// queue can never overflow. A flush empties the queue; responses still in
// flight at that point are counted and dropped in DRAIN.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ce, pc                   fetch enable and fetch address from PC stage
//   flush                    branch taken, discard queued and in-flight work
//   fetch_stall              PC stage must hold pc (no request fired)
//   mem_req, mem_addr        instruction memory request, word-aligned address
//   mem_gnt                  memory accepts the request this cycle
//   mem_rvalid, mem_rdata    in-order response
//   id_valid, id_inst, id_pc head entry toward decode
//   id_ready                 decode consumes the head entry
// -----------------------------------------------------------------------------
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        fetch_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    localparam int QCNT_W = $clog2(DEPTH + 1);
    localparam int OCNT_W = $clog2(MAX_OUT + 1);
    localparam int SUM_W  = ((QCNT_W > OCNT_W) ? QCNT_W : OCNT_W) + 1;

    fq_state_e         state_q, state_d;
    logic [OCNT_W-1:0] discard_q, discard_d;

    logic [QCNT_W-1:0] q_count;
    logic [OCNT_W-1:0] outstanding;
    fq_entry_t         q_wdata, q_head;
    logic              q_push, q_pop, q_clr;
    logic              a_push, a_pop, a_clr;
    logic [31:0]       a_head;
    logic              rsp_accept;
    logic              slot_free;

    // Queued entries plus in-flight requests must fit in the queue.
    assign slot_free = (SUM_W'(q_count) + SUM_W'(outstanding)) < SUM_W'(DEPTH);

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        mem_req    = 1'b0;
        rsp_accept = 1'b0;
        q_push     = 1'b0;
        q_pop      = 1'b0;
        q_clr      = 1'b0;
        a_pop      = 1'b0;
        a_clr      = 1'b0;
        case (state_q)
            RUN: begin
                mem_req    = ce & ~flush & slot_free & (outstanding < OCNT_W'(MAX_OUT));
                // A response with nothing in flight is stray and ignored.
                rsp_accept = mem_rvalid & (outstanding != '0);
                if (flush) begin
                    q_clr     = 1'b1;
                    a_clr     = 1'b1;
                    discard_d = outstanding - OCNT_W'(rsp_accept);
                    if (discard_d != '0) state_d = DRAIN;
                end else begin
                    q_push = rsp_accept;
                    a_pop  = rsp_accept;
                    q_pop  = id_valid & id_ready;
                end
            end
            DRAIN: begin
                q_clr = flush;
                if (mem_rvalid && discard_q != '0) begin
                    discard_d = discard_q - 1'b1;
                    if (discard_q == OCNT_W'(1)) state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    assign a_push      = mem_req & mem_gnt;
    assign fetch_stall = ~a_push;
    assign mem_addr    = {pc[31:2], 2'b00};

    assign q_wdata.pc   = a_head;
    assign q_wdata.inst = mem_rdata;

    // In-flight address FIFO: its count is the outstanding-request counter.
    sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_addr_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (a_clr),
        .push  (a_push),
        .wdata (pc),
        .pop   (a_pop),
        .rdata (a_head),
        .count (outstanding)
    );

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clr   (q_clr),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_head),
        .count (q_count)
    );

    assign id_valid = (q_count != '0);
    assign id_inst  = q_head.inst;
    assign id_pc    = q_head.pc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
// Directed, table-driven bench for inst_fetch_queue (DEPTH=4, MAX_OUT=2).
// Each table row is one clock cycle: inputs are driven after the falling edge,
// outputs compared 1 ns later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic        flush;
    logic        fetch_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.DEPTH(4), .MAX_OUT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .pc          (pc),
        .flush       (flush),
        .fetch_stall (fetch_stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_ready    (id_ready)
    );

    typedef struct {
        logic        rst, ce;
        logic [31:0] pc;
        logic        flush, gnt, rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req, e_stall;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_idpc, e_idinst;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic c, input logic [31:0] p, input logic f,
                       input logic g, input logic v, input logic [31:0] d, input logic y,
                       input logic er, input logic es, input logic [31:0] ea,
                       input logic ev, input logic [31:0] ep, input logic [31:0] ei);
        vec_t t;
        t.rst = r; t.ce = c; t.pc = p; t.flush = f; t.gnt = g; t.rv = v; t.rdata = d; t.rdy = y;
        t.e_req = er; t.e_stall = es; t.e_addr = ea; t.e_idv = ev; t.e_idpc = ep; t.e_idinst = ei;
        vecs.push_back(t);
    endtask

    initial begin
        int n_rsp;
        int idv_seen;
        bit seen_req;

        //   rst ce pc          fl gnt rv rdata          rdy | req stall addr       idv id_pc      id_inst
        // Reset state, then streaming with 1-cycle latency and no bubbles
        add(0, 0, 32'h00,     0, 0, 0, 32'h0,          0,    0, 1, 32'h00,     0, 32'h0,      32'h0);
        add(0, 1, 32'h00,     0, 1, 0, 32'h0,          1,    1, 0, 32'h00,     0, 32'h0,      32'h0);
        add(0, 1, 32'h04,     0, 1, 1, 32'hA000_0000,  1,    1, 0, 32'h04,     0, 32'h0,      32'h0);
        add(0, 1, 32'h08,     0, 1, 1, 32'hA000_0004,  1,    1, 0, 32'h08,     1, 32'h00,     32'hA000_0000);
        add(0, 0, 32'h0C,     0, 1, 1, 32'hA000_0008,  1,    0, 1, 32'h0C,     1, 32'h04,     32'hA000_0004);
        add(0, 0, 32'h0C,     0, 1, 0, 32'h0,          1,    0, 1, 32'h0C,     1, 32'h08,     32'hA000_0008);
        // Unaligned pc is word-aligned on the request bus
        add(0, 0, 32'h06,     0, 1, 0, 32'h0,          1,    0, 1, 32'h04,     0, 32'h0,      32'h0);
        // Decode stalled: exactly four requests fire, then hold until a pop
        add(0, 1, 32'h20,     0, 1, 0, 32'h0,          0,    1, 0, 32'h20,     0, 32'h0,      32'h0);
        add(0, 1, 32'h24,     0, 1, 1, 32'hB000_0020,  0,    1, 0, 32'h24,     0, 32'h0,      32'h0);
        add(0, 1, 32'h28,     0, 1, 1, 32'hB000_0024,  0,    1, 0, 32'h28,     1, 32'h20,     32'hB000_0020);
        add(0, 1, 32'h2C,     0, 1, 1, 32'hB000_0028,  0,    1, 0, 32'h2C,     1, 32'h20,     32'hB000_0020);
        add(0, 1, 32'h30,     0, 1, 1, 32'hB000_002C,  0,    0, 1, 32'h30,     1, 32'h20,     32'hB000_0020);
        add(0, 1, 32'h30,     0, 1, 0, 32'h0,          0,    0, 1, 32'h30,     1, 32'h20,     32'hB000_0020);
        add(0, 1, 32'h30,     0, 1, 0, 32'h0,          1,    0, 1, 32'h30,     1, 32'h20,     32'hB000_0020);
        add(0, 1, 32'h30,     0, 1, 0, 32'h0,          0,    1, 0, 32'h30,     1, 32'h24,     32'hB000_0024);
        // Flush with a full-ish queue and one request in flight
        add(0, 1, 32'h34,     1, 1, 0, 32'h0,          1,    0, 1, 32'h34,     1, 32'h24,     32'hB000_0024);
        add(0, 1, 32'h34,     0, 1, 0, 32'h0,          0,    0, 1, 32'h34,     0, 32'h0,      32'h0);
        add(0, 1, 32'h34,     0, 1, 1, 32'hDEAD_0030,  0,    0, 1, 32'h34,     0, 32'h0,      32'h0);
        add(0, 1, 32'h34,     0, 1, 0, 32'h0,          1,    1, 0, 32'h34,     0, 32'h0,      32'h0);
        add(0, 0, 32'h38,     0, 1, 1, 32'hB000_0034,  1,    0, 1, 32'h38,     0, 32'h0,      32'h0);
        add(0, 0, 32'h38,     0, 1, 0, 32'h0,          1,    0, 1, 32'h38,     1, 32'h34,     32'hB000_0034);
        // Two outstanding (0x10, 0x14), flush, both dropped, refetch at 0x100
        add(0, 1, 32'h10,     0, 1, 0, 32'h0,          1,    1, 0, 32'h10,     0, 32'h0,      32'h0);
        add(0, 1, 32'h14,     0, 1, 0, 32'h0,          1,    1, 0, 32'h14,     0, 32'h0,      32'h0);
        add(0, 1, 32'h18,     1, 1, 0, 32'h0,          1,    0, 1, 32'h18,     0, 32'h0,      32'h0);
        add(0, 1, 32'h100,    0, 1, 1, 32'hC000_0010,  1,    0, 1, 32'h100,    0, 32'h0,      32'h0);
        add(0, 1, 32'h100,    0, 1, 1, 32'hC000_0014,  1,    0, 1, 32'h100,    0, 32'h0,      32'h0);
        add(0, 1, 32'h100,    0, 1, 0, 32'h0,          1,    1, 0, 32'h100,    0, 32'h0,      32'h0);
        add(0, 0, 32'h104,    0, 1, 1, 32'hC000_0100,  1,    0, 1, 32'h104,    0, 32'h0,      32'h0);
        add(0, 0, 32'h104,    0, 1, 0, 32'h0,          1,    0, 1, 32'h104,    1, 32'h100,    32'hC000_0100);
        // Flush coincident with a response and a pop: discard = 2 - 1
        add(0, 1, 32'h40,     0, 1, 0, 32'h0,          0,    1, 0, 32'h40,     0, 32'h0,      32'h0);
        add(0, 1, 32'h44,     0, 1, 1, 32'hD000_0040,  0,    1, 0, 32'h44,     0, 32'h0,      32'h0);
        add(0, 1, 32'h48,     0, 1, 0, 32'h0,          0,    1, 0, 32'h48,     1, 32'h40,     32'hD000_0040);
        add(0, 1, 32'h4C,     1, 1, 1, 32'hD000_0044,  1,    0, 1, 32'h4C,     1, 32'h40,     32'hD000_0040);
        add(0, 0, 32'h4C,     0, 1, 0, 32'h0,          1,    0, 1, 32'h4C,     0, 32'h0,      32'h0);
        add(0, 0, 32'h4C,     0, 1, 1, 32'hD000_0048,  1,    0, 1, 32'h4C,     0, 32'h0,      32'h0);
        add(0, 1, 32'h4C,     0, 0, 0, 32'h0,          1,    1, 1, 32'h4C,     0, 32'h0,      32'h0);
        // Reset while in DRAIN with discard = 2
        add(0, 1, 32'h50,     0, 1, 0, 32'h0,          1,    1, 0, 32'h50,     0, 32'h0,      32'h0);
        add(0, 1, 32'h54,     0, 1, 0, 32'h0,          1,    1, 0, 32'h54,     0, 32'h0,      32'h0);
        add(0, 0, 32'h58,     1, 1, 0, 32'h0,          1,    0, 1, 32'h58,     0, 32'h0,      32'h0);
        add(1, 1, 32'h58,     0, 1, 0, 32'h0,          1,    0, 1, 32'h58,     0, 32'h0,      32'h0);
        add(0, 1, 32'h60,     0, 0, 0, 32'h0,          1,    1, 1, 32'h60,     0, 32'h0,      32'h0);
        // Stray response with nothing outstanding is ignored
        add(0, 0, 32'h60,     0, 1, 1, 32'hE000_0000,  1,    0, 1, 32'h60,     0, 32'h0,      32'h0);
        add(0, 0, 32'h60,     0, 1, 0, 32'h0,          1,    0, 1, 32'h60,     0, 32'h0,      32'h0);
        // Outstanding restarted from zero: two fire, third blocked by MAX_OUT
        add(0, 1, 32'h60,     0, 1, 0, 32'h0,          1,    1, 0, 32'h60,     0, 32'h0,      32'h0);
        add(0, 1, 32'h64,     0, 1, 0, 32'h0,          1,    1, 0, 32'h64,     0, 32'h0,      32'h0);
        add(0, 1, 32'h68,     0, 1, 0, 32'h0,          1,    0, 1, 32'h68,     0, 32'h0,      32'h0);

        rst = 1'b1; ce = 1'b0; pc = '0; flush = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; id_ready = 1'b0;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst        = vecs[i].rst;
            ce         = vecs[i].ce;
            pc         = vecs[i].pc;
            flush      = vecs[i].flush;
            mem_gnt    = vecs[i].gnt;
            mem_rvalid = vecs[i].rv;
            mem_rdata  = vecs[i].rdata;
            id_ready   = vecs[i].rdy;
            #1;
            check($sformatf("v%0d.mem_req", i),     32'(mem_req),     32'(vecs[i].e_req));
            check($sformatf("v%0d.fetch_stall", i), 32'(fetch_stall), 32'(vecs[i].e_stall));
            check($sformatf("v%0d.mem_addr", i),    mem_addr,         vecs[i].e_addr);
            check($sformatf("v%0d.id_valid", i),    32'(id_valid),    32'(vecs[i].e_idv));
            if (vecs[i].e_idv) begin
                check($sformatf("v%0d.id_pc", i),   id_pc,   vecs[i].e_idpc);
                check($sformatf("v%0d.id_inst", i), id_inst, vecs[i].e_idinst);
            end
        end

        // Hand sequence: two requests (0x60, 0x64) are outstanding. Flush, then
        // feed responses until mem_req returns; exactly two must be dropped.
        @(negedge clk);
        rst = 1'b0; ce = 1'b0; flush = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; id_ready = 1'b1;
        n_rsp    = 0;
        idv_seen = 0;
        seen_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            flush      = 1'b0;
            ce         = 1'b1;
            pc         = 32'h200;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hF000_0000 + 32'(k);
            #1;
            if (mem_req) begin
                seen_req = 1'b1;
                break;
            end
            if (id_valid) idv_seen++;
            n_rsp++;
        end
        check("drain.timeout",    32'(seen_req), 32'd1);
        check("drain.responses",  32'(n_rsp),    32'd2);
        check("drain.id_valid",   32'(idv_seen), 32'd0);

        @(negedge clk);
        ce = 1'b0; mem_rvalid = 1'b0;
        #1;
        check("post_drain.id_valid", 32'(id_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
